// File: rtl/product_accumulator.sv
// product_accumulator: sums fixed-length batches of 8-bit unsigned products
// into an ACC_W-bit accumulator and presents each finished batch on a
// valid/ready handshake, together with a sticky per-batch carry-out flag.
module product_accumulator #(
    parameter int unsigned N_TERMS = 4,
    parameter int unsigned ACC_W   = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_product,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             overflow,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(N_TERMS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_TERMS);
    localparam bit SINGLE_TERM = (N_TERMS == 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;

    logic               accept;
    logic [ACC_W:0]     sum_ext;
    logic [CNT_W-1:0]   cnt_inc;

    // Input acceptance: blocked while a result is held or a clear is pending.
    always_comb begin
        in_ready = (state_q != HOLD) && !clear;
        accept   = in_valid && in_ready;
    end

    // Next-state, accumulate and handshake logic; clear overrides everything.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        sum_ext     = {1'b0, acc_q} + (ACC_W + 1)'(in_product);
        cnt_inc     = cnt_q + CNT_W'(1);

        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        acc_d   = ACC_W'(in_product);
                        ovf_d   = 1'b0;
                        cnt_d   = CNT_W'(1);
                        state_d = SINGLE_TERM ? HOLD : ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc_d = sum_ext[ACC_W-1:0];
                        ovf_d = ovf_q | sum_ext[ACC_W];
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_LAST) begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_d = IDLE;
                        acc_d   = '0;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            endcase
        end

        out_valid_d = (state_d == HOLD);
        busy_d      = (state_d == ACCUM);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // The running sum is visible in every state; out_valid qualifies it.
    always_comb begin
        out_sum   = acc_q;
        overflow  = ovf_q;
        out_valid = out_valid_q;
        busy      = busy_q;
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench for product_accumulator: instance A uses the default
// sizing, instance B (ACC_W=8, N_TERMS=2) exercises the carry-out flag.
module tb_product_accumulator;

    typedef struct packed {
        logic [11:0] sum;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        a_clear, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic        a_overflow, a_busy;
    logic [7:0]  a_in_product;
    logic [11:0] a_out_sum;

    logic        b_clear, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic        b_overflow, b_busy;
    logic [7:0]  b_in_product;
    logic [7:0]  b_out_sum;

    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        qa[$];
    exp_t        qb[$];
    exp_t        ea, eb;

    always #5 clk = ~clk;

    product_accumulator #(.N_TERMS(4), .ACC_W(12)) u_dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (a_clear),
        .in_valid   (a_in_valid),
        .in_ready   (a_in_ready),
        .in_product (a_in_product),
        .out_valid  (a_out_valid),
        .out_ready  (a_out_ready),
        .out_sum    (a_out_sum),
        .overflow   (a_overflow),
        .busy       (a_busy)
    );

    product_accumulator #(.N_TERMS(2), .ACC_W(8)) u_dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (b_clear),
        .in_valid   (b_in_valid),
        .in_ready   (b_in_ready),
        .in_product (b_in_product),
        .out_valid  (b_out_valid),
        .out_ready  (b_out_ready),
        .out_sum    (b_out_sum),
        .overflow   (b_overflow),
        .busy       (b_busy)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // Inputs change only 2 time units after a rising edge.
    task automatic to_drive();
        @(posedge clk);
        #2;
    endtask

    // Present one product and hold it until the DUT has taken it.
    task automatic send(input bit use_b, input logic [7:0] p);
        bit ok;
        int n;
        ok = 1'b0;
        n  = 0;
        if (use_b) begin
            b_in_valid = 1'b1; b_in_product = p;
        end else begin
            a_in_valid = 1'b1; a_in_product = p;
        end
        while (!ok && n < 50) begin
            at_neg();
            ok = use_b ? b_in_ready : a_in_ready;
            to_drive();
            n++;
        end
        if (use_b) b_in_valid = 1'b0;
        else       a_in_valid = 1'b0;
        check(use_b ? "b_send_accepted" : "a_send_accepted", int'(ok), 1);
    endtask

    // Result monitor: every completed handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL a_unexpected_result: got sum %0d, expected no result", a_out_sum);
            end else begin
                ea = qa.pop_front();
                check("a_out_sum", int'(a_out_sum), int'(ea.sum));
                check("a_overflow", int'(a_overflow), int'(ea.ovf));
            end
        end
        if (rst_n && b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL b_unexpected_result: got sum %0d, expected no result", b_out_sum);
            end else begin
                eb = qb.pop_front();
                check("b_out_sum", int'(b_out_sum), int'(eb.sum));
                check("b_overflow", int'(b_overflow), int'(eb.ovf));
            end
        end
    end

    // Hard stop if the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        a_clear = 1'b0; a_in_valid = 1'b0; a_in_product = 8'd0; a_out_ready = 1'b0;
        b_clear = 1'b0; b_in_valid = 1'b0; b_in_product = 8'd0; b_out_ready = 1'b0;

        // Reset state
        #1;
        check("rst_a_out_valid", int'(a_out_valid), 0);
        check("rst_a_out_sum", int'(a_out_sum), 0);
        check("rst_a_overflow", int'(a_overflow), 0);
        check("rst_a_busy", int'(a_busy), 0);
        check("rst_a_in_ready", int'(a_in_ready), 1);
        check("rst_b_out_valid", int'(b_out_valid), 0);
        to_drive();
        to_drive();
        rst_n = 1'b1;

        // Four back-to-back 225s
        a_out_ready = 1'b1;
        qa.push_back('{sum: 12'd900, ovf: 1'b0});
        repeat (4) send(1'b0, 8'd225);
        at_neg();
        check("t1_out_valid", int'(a_out_valid), 1);
        check("t1_in_ready_hold", int'(a_in_ready), 0);
        to_drive();
        at_neg();
        check("t1_out_valid_drop", int'(a_out_valid), 0);
        check("t1_in_ready_again", int'(a_in_ready), 1);
        to_drive();

        // 6, 0, 15, 9 with two idle cycles between products
        qa.push_back('{sum: 12'd30, ovf: 1'b0});
        at_neg();
        check("t2_busy_before", int'(a_busy), 0);
        to_drive();
        send(1'b0, 8'd6);
        repeat (2) begin at_neg(); check("t2_busy_gap1", int'(a_busy), 1); to_drive(); end
        send(1'b0, 8'd0);
        repeat (2) begin at_neg(); check("t2_sum_gap2", int'(a_out_sum), 6); to_drive(); end
        send(1'b0, 8'd15);
        repeat (2) begin at_neg(); check("t2_sum_gap3", int'(a_out_sum), 21); to_drive(); end
        send(1'b0, 8'd9);
        at_neg();
        check("t2_busy_after", int'(a_busy), 0);
        to_drive();

        // Backpressure: hold 900 for five cycles with in_valid pushed at it
        a_out_ready = 1'b0;
        qa.push_back('{sum: 12'd900, ovf: 1'b0});
        repeat (4) send(1'b0, 8'd225);
        a_in_valid = 1'b1;
        a_in_product = 8'd77;
        repeat (5) begin
            at_neg();
            check("t3_hold_valid", int'(a_out_valid), 1);
            check("t3_hold_sum", int'(a_out_sum), 900);
            check("t3_hold_in_ready", int'(a_in_ready), 0);
            to_drive();
        end
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        at_neg();
        to_drive();
        at_neg();
        check("t3_released_valid", int'(a_out_valid), 0);
        check("t3_released_sum", int'(a_out_sum), 0);
        to_drive();

        // Narrow accumulator: carry out, then a clean batch clears the flag
        b_out_ready = 1'b1;
        qb.push_back('{sum: 12'd44, ovf: 1'b1});
        send(1'b1, 8'd200);
        at_neg();
        check("t4_b_busy", int'(b_busy), 1);
        to_drive();
        send(1'b1, 8'd100);
        at_neg();
        to_drive();
        qb.push_back('{sum: 12'd3, ovf: 1'b0});
        send(1'b1, 8'd1);
        send(1'b1, 8'd2);
        at_neg();
        to_drive();

        // clear after two products, with a product offered in the same cycle
        send(1'b0, 8'd7);
        send(1'b0, 8'd8);
        a_clear = 1'b1;
        a_in_valid = 1'b1;
        a_in_product = 8'd50;
        at_neg();
        check("t5_in_ready_clear", int'(a_in_ready), 0);
        to_drive();
        a_clear = 1'b0;
        a_in_valid = 1'b0;
        at_neg();
        check("t5_sum_cleared", int'(a_out_sum), 0);
        check("t5_busy_cleared", int'(a_busy), 0);
        to_drive();
        qa.push_back('{sum: 12'd4, ovf: 1'b0});
        repeat (4) send(1'b0, 8'd1);
        at_neg();
        to_drive();

        // Asynchronous reset mid-batch
        send(1'b0, 8'd10);
        send(1'b0, 8'd10);
        rst_n = 1'b0;
        #1;
        check("t6_mid_sum", int'(a_out_sum), 0);
        check("t6_mid_busy", int'(a_busy), 0);
        check("t6_mid_valid", int'(a_out_valid), 0);
        to_drive();
        rst_n = 1'b1;

        // Asynchronous reset while a result is held
        a_out_ready = 1'b0;
        repeat (4) send(1'b0, 8'd10);
        at_neg();
        check("t6_hold_valid", int'(a_out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_hold_valid_rst", int'(a_out_valid), 0);
        check("t6_hold_sum_rst", int'(a_out_sum), 0);
        check("t6_hold_ovf_rst", int'(a_overflow), 0);
        to_drive();
        rst_n = 1'b1;
        a_out_ready = 1'b1;
        qa.push_back('{sum: 12'd40, ovf: 1'b0});
        repeat (4) send(1'b0, 8'd10);
        at_neg();
        to_drive();
        at_neg();

        check("a_results_drained", qa.size(), 0);
        check("b_results_drained", qb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Sequential stage directly downstream of the 4x4 unsigned multiplier. It consumes the 8-bit products and sums a fixed-length batch of N_TERMS products into a wider accumulator, as a dot-product / multiply-accumulate back end.
- It presents each finished sum on a valid/ready output handshake, with a sticky overflow flag.
- Input side is valid/ready so an operand sequencer driving the multiplier can be stalled.

Parameters:
- N_TERMS, 4, number of products summed per batch; legal range 1..255.
- ACC_W, 12, accumulator/out_sum width in bits; legal minimum 8.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- clear  input  1  synchronous abort: discard the current batch and return to idle
- in_valid  input  1  in_product is valid this cycle
- in_ready  output  1  block can accept a product this cycle
- in_product  input  8  unsigned product from the multiplier
- out_valid  output  1  out_sum / overflow hold a completed batch
- out_ready  input  1  consumer accepts the completed batch
- out_sum  output  ACC_W  batch sum, modulo 2^ACC_W
- overflow  output  1  carry out of ACC_W occurred during the batch (sticky per batch)
- busy  output  1  a batch is partially accumulated (state ACCUM)

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, acc=0, cnt=0, out_sum=0, out_valid=0, overflow=0, busy=0. Reset mid-batch discards all partial data.
- States:
  - IDLE: no data held.
  - ACCUM: 1..N_TERMS-1 products taken.
  - HOLD: result presented.
- in_ready = (state != HOLD) && !clear. It is combinational from registered state plus clear.
- Accept event = in_valid && in_ready, sampled at the rising edge.
- IDLE + accept:
  - acc <= zero-extended in_product, overflow <= 0, cnt <= 1.
  - Next state is HOLD if N_TERMS==1, else ACCUM.
  - This clears the previous batch's overflow.
- ACCUM + accept:
  - acc <= (acc + in_product) mod 2^ACC_W; overflow <= overflow | carry-out; cnt <= cnt+1.
  - Next state is HOLD when cnt+1 == N_TERMS.
- IDLE/ACCUM without accept: all registers hold. Gaps in in_valid of any length are legal.
- HOLD:
  - out_valid=1; out_sum and overflow must stay stable while out_ready=0.
  - On out_ready=1: next state IDLE, out_valid=0 after that edge, acc and cnt <= 0.
  - No input accepted in HOLD, including in the handshake cycle. The earliest next accept is the cycle after out_valid drops.
- out_sum reflects acc in every state (a partial sum is visible while busy). Consumers qualify it with out_valid.
- Latency: the final product accepted at edge k gives out_valid=1 immediately after edge k. Full-rate batch = N_TERMS cycles plus 1 handshake cycle minimum.
- clear=1 (synchronous, priority over every other transition):
  - Next state IDLE; acc, cnt, overflow, out_valid <= 0.
  - in_ready is forced 0, so no product is consumed that cycle.
  - clear in HOLD drops an unconsumed result, even if out_ready=1 that cycle.
- Arithmetic: unsigned only; the product is zero-extended to ACC_W before the add. The carry-out is bit ACC_W of the (ACC_W+1)-bit sum.
- Default sizing: 4*225=900 < 4096, so overflow is never set with the defaults. Overflow is meaningful only for small ACC_W or large N_TERMS.
- cnt width = clog2(N_TERMS+1). cnt never exceeds N_TERMS.

Test Plan:
- N_TERMS=4, ACC_W=12, four back-to-back products of 225 (15x15) with out_ready=1 → out_valid=1 for one cycle after the 4th accept; out_sum=900 (0x384); overflow=0; in_ready=1 again next cycle.
- Same config, products 6, 0, 15, 9 with 2-cycle in_valid gaps between each → busy=1 from the 1st to the 4th accept; out_sum=30; no extra products counted during gaps.
- Backpressure: completed batch with sum 900, out_ready=0 for 5 cycles → out_sum=900 and out_valid=1 stable; in_ready=0 and in_valid=1 ignored; release out_ready → IDLE next cycle.
- ACC_W=8, N_TERMS=2, products 200 then 100 → out_sum=44 (300 mod 256); overflow=1. Next batch of 1 and 2 → out_sum=3; overflow=0.
- clear asserted after 2 of 4 products, in_valid=1 with product 50 in the same cycle → state IDLE, acc=0; product 50 not consumed. Next 4 products of 1 → out_sum=4.
- rst_n pulsed low asynchronously (between edges) mid-batch and again during HOLD → all outputs 0 immediately; a fresh batch of 4x10 after release → out_sum=40.
